pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. It drives the hold (keep current value) and flush (load bubble) controls of the PC register and the IF/ID and ID/EX pipeline registers. It detects load-use hazards and inserts a configurable number of bubbles. It applies EX-stage jump redirects and freezes the front end while the load/store unit is busy.

---
 rtl/pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | pipe_ctrl: PC/IF-ID/ID-EX hold+flush sequencing (load-use, redirect, LSU freeze);        |
// | optional PIPE_CTRL_PERF_EN adds stall/flush counters.            Revision 1.0            |
// +----------------------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int AW       = 32,
  parameter int RW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_jump_en,
  input  logic [AW-1:0] ex_jump_addr,
  input  logic          ex_mem_rd,
  input  logic [RW-1:0] ex_rd,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_use,
  input  logic          id_rs2_use,
  input  logic          lsu_busy,
  output logic          pc_hold,
  output logic          ifid_hold,
  output logic          idex_hold,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          redirect_en,
  output logic [AW-1:0] redirect_pc
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] c_LU_INIT = 3'(LOAD_LAT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_ret;        // 1: resume LU_STALL after the LSU wait, 0: resume RUN

  state_t     w_state_nx;
  state_t     w_eff;
  logic [2:0] w_cnt_nx;
  logic       w_ret_nx;
  logic       w_hz;
  logic       w_pc_hold;
  logic       w_ifid_hold;
  logic       w_idex_hold;
  logic       w_ifid_flush;
  logic       w_idex_flush;
  logic       w_redirect;

  always_comb begin
    w_hz = ex_mem_rd && (ex_rd != '0) &&
           ((id_rs1_use && (id_rs1 == ex_rd)) || (id_rs2_use && (id_rs2 == ex_rd)));
  end

  // Once the LSU releases, MEM_WAIT acts exactly like the state it interrupted.
  always_comb begin
    w_eff = r_state;
    if (r_state == ST_MEM_WAIT) begin
      w_eff = r_ret ? ST_LU_STALL : ST_RUN;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_ret_nx     = r_ret;
    w_pc_hold    = 1'b0;
    w_ifid_hold  = 1'b0;
    w_idex_hold  = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_redirect   = 1'b0;

    if (lsu_busy) begin
      w_pc_hold   = 1'b1;
      w_ifid_hold = 1'b1;
      w_idex_hold = 1'b1;
      w_state_nx  = ST_MEM_WAIT;
      w_ret_nx    = (w_eff == ST_LU_STALL);
    end else if (ex_jump_en) begin
      w_redirect   = 1'b1;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_state_nx   = ST_RUN;
    end else if (w_eff == ST_LU_STALL) begin
      w_pc_hold    = 1'b1;
      w_ifid_hold  = 1'b1;
      w_idex_flush = 1'b1;
      if (r_cnt == 3'd1) begin
        w_cnt_nx   = 3'd0;
        w_state_nx = ST_RUN;
      end else begin
        w_cnt_nx   = r_cnt - 3'd1;
        w_state_nx = ST_LU_STALL;
      end
    end else if (w_hz) begin
      w_pc_hold    = 1'b1;
      w_ifid_hold  = 1'b1;
      w_idex_flush = 1'b1;
      if (LOAD_LAT > 1) begin
        w_cnt_nx   = c_LU_INIT;
        w_state_nx = ST_LU_STALL;
      end else begin
        w_state_nx = ST_RUN;
      end
    end else begin
      w_state_nx = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
      r_ret   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ret   <= w_ret_nx;
    end
  end

  // Reset forces every control low in the same cycle, independent of state.
  assign pc_hold     = w_pc_hold    & ~rst;
  assign ifid_hold   = w_ifid_hold  & ~rst;
  assign idex_hold   = w_idex_hold  & ~rst;
  assign ifid_flush  = w_ifid_flush & ~rst;
  assign idex_flush  = w_idex_flush & ~rst;
  assign redirect_en = w_redirect   & ~rst;
  assign redirect_pc = redirect_en ? ex_jump_addr : '0;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (pc_hold && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect_en && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_pipe_ctrl: directed bench, LOAD_LAT=1 and LOAD_LAT=3 instances  |
// | driven in parallel.                               Revision 1.0     |
// +-------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int RW = 5;

  // {pc_hold, ifid_hold, idex_hold, ifid_flush, idex_flush, redirect_en}
  localparam logic [5:0] c_NONE = 6'b000000;
  localparam logic [5:0] c_HOLD = 6'b111000;
  localparam logic [5:0] c_BUB  = 6'b110010;
  localparam logic [5:0] c_JMP  = 6'b000111;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_jump_en;
  logic [AW-1:0] ex_jump_addr;
  logic          ex_mem_rd;
  logic [RW-1:0] ex_rd;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_use;
  logic          id_rs2_use;
  logic          lsu_busy;

  logic          a_pc_hold, a_ifid_hold, a_idex_hold, a_ifid_flush, a_idex_flush, a_redir;
  logic [AW-1:0] a_redir_pc;
  logic          b_pc_hold, b_ifid_hold, b_idex_hold, b_ifid_flush, b_idex_flush, b_redir;
  logic [AW-1:0] b_redir_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   a_pstall, a_pflush, b_pstall, b_pflush;
  logic [31:0]   b_pstall_base;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.AW(AW), .RW(RW), .LOAD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
    .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .lsu_busy(lsu_busy),
    .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .idex_hold(a_idex_hold),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
    .redirect_en(a_redir), .redirect_pc(a_redir_pc)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush)
`endif
  );

  pipe_ctrl #(.AW(AW), .RW(RW), .LOAD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
    .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .lsu_busy(lsu_busy),
    .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .idex_hold(b_idex_hold),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
    .redirect_en(b_redir), .redirect_pc(b_redir_pc)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check both instances' control vectors and redirect targets.
  task automatic chk2(input string tag, input logic [5:0] exp_a, input logic [5:0] exp_b,
                      input logic [31:0] exp_pc);
    chk({tag, " lat1"}, {26'd0, a_pc_hold, a_ifid_hold, a_idex_hold, a_ifid_flush, a_idex_flush, a_redir}, {26'd0, exp_a});
    chk({tag, " lat3"}, {26'd0, b_pc_hold, b_ifid_hold, b_idex_hold, b_ifid_flush, b_idex_flush, b_redir}, {26'd0, exp_b});
    chk({tag, " pc1"}, a_redir_pc, exp_pc);
    chk({tag, " pc3"}, b_redir_pc, exp_pc);
  endtask

  task automatic idle();
    ex_jump_en = 1'b0; ex_jump_addr = '0; ex_mem_rd = 1'b0; ex_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_use = 1'b0; id_rs2_use = 1'b0; lsu_busy = 1'b0;
  endtask

  task automatic hazard();
    idle();
    ex_mem_rd = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_use = 1'b1;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks follow at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    hazard();
    ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0100;
    #2;
    chk2("reset_outputs", c_NONE, c_NONE, 32'h0);
    tick();
    tick();
    rst = 1'b0; idle(); #1;
    chk2("post_reset_idle", c_NONE, c_NONE, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_reset_stall", b_pstall, 32'd0);
`endif

    tick(); hazard(); #1;
    chk2("lu_hazard_c1", c_BUB, c_BUB, 32'h0);
    tick(); idle(); #1;
    chk2("lu_hazard_c2", c_NONE, c_BUB, 32'h0);
    tick(); #1;
    chk2("lu_hazard_c3", c_NONE, c_BUB, 32'h0);
    tick(); #1;
    chk2("lu_hazard_done", c_NONE, c_NONE, 32'h0);

    tick(); idle(); ex_mem_rd = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_use = 1'b1; #1;
    chk2("x0_no_stall", c_NONE, c_NONE, 32'h0);
    tick(); idle(); ex_mem_rd = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_use = 1'b0; #1;
    chk2("rs2_unused_no_stall", c_NONE, c_NONE, 32'h0);

    tick(); hazard(); ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0100; #1;
    chk2("jump_beats_hazard", c_JMP, c_JMP, 32'h0000_0100);
    tick(); idle(); #1;
    chk2("after_jump_idle", c_NONE, c_NONE, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
    b_pstall_base = b_pstall;
`endif
    tick(); hazard(); #1;
    chk2("lsu_hz_bubble1", c_BUB, c_BUB, 32'h0);
    tick(); idle(); #1;
    chk2("lsu_hz_bubble2", c_NONE, c_BUB, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); lsu_busy = 1'b1; ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0300; #1;
      chk2($sformatf("lsu_freeze_%0d", i), c_HOLD, c_HOLD, 32'h0);
    end
    tick(); idle(); #1;
    chk2("lsu_resume_bubble3", c_NONE, c_BUB, 32'h0);
    tick(); #1;
    chk2("lsu_back_to_run", c_NONE, c_NONE, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_plus7", b_pstall - b_pstall_base, 32'd7);
`endif

    tick(); hazard(); #1;
    chk2("abort_bubble", c_BUB, c_BUB, 32'h0);
    tick(); idle(); ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0200; #1;
    chk2("abort_redirect", c_JMP, c_JMP, 32'h0000_0200);
    tick(); idle(); #1;
    chk2("abort_then_run", c_NONE, c_NONE, 32'h0);

    tick(); hazard(); #1;
    chk2("rst_mid_bubble", c_BUB, c_BUB, 32'h0);
    tick(); idle(); rst = 1'b1; ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0400; #1;
    chk2("rst_mid_stall", c_NONE, c_NONE, 32'h0);
    tick(); idle(); rst = 1'b0; #1;
    chk2("rst_abandons_stall", c_NONE, c_NONE, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cleared", b_pstall, 32'd0);
    chk("perf_flush_cleared", b_pflush, 32'd0);
    chk("perf_a_cleared", a_pstall | a_pflush, 32'd0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
